// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters share one WIDTH-bit add/subtract unit.
// Round-robin grant in IDLE, result held in RESP until the owner takes it.
module addsub_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             VALID0,
    input  logic             VALID1,
    output logic             READY0,
    output logic             READY1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    input  logic             OP0,
    input  logic             OP1,
    output logic             OUT_VALID0,
    output logic             OUT_VALID1,
    input  logic             OUT_READY0,
    input  logic             OUT_READY1,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             BUSY
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             ptr;        // 1: requester 1 has priority on a tie
    logic             owner;      // requester whose result is held
    logic             grant_vld;
    logic             grant_sel;
    logic             op_sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] o_p0;
    logic             cout_p0;

    // Single adder with carry-in; subtraction is A + ~B + 1.
    function automatic logic [WIDTH:0] add_cin(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             cin);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    endfunction

    // Arbitration, handshake outputs and next-state decision.
    always_comb begin
        state_nxt  = state;
        grant_vld  = 1'b0;
        grant_sel  = 1'b0;
        READY0     = 1'b0;
        READY1     = 1'b0;
        OUT_VALID0 = 1'b0;
        OUT_VALID1 = 1'b0;
        BUSY       = 1'b0;
        case (state)
            IDLE: begin
                if (VALID0 && VALID1) begin
                    grant_vld = 1'b1;
                    grant_sel = ptr;
                end else if (VALID0) begin
                    grant_vld = 1'b1;
                    grant_sel = 1'b0;
                end else if (VALID1) begin
                    grant_vld = 1'b1;
                    grant_sel = 1'b1;
                end
                if (grant_vld) begin
                    READY0    = ~grant_sel;
                    READY1    = grant_sel;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                BUSY       = 1'b1;
                OUT_VALID0 = ~owner;
                OUT_VALID1 = owner;
                if ((owner == 1'b0 && OUT_READY0) || (owner == 1'b1 && OUT_READY1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand selection for the granted requester feeding the shared adder.
    always_comb begin
        op_a   = grant_sel ? A1 : A0;
        op_b   = grant_sel ? B1 : B0;
        op_sub = grant_sel ? OP1 : OP0;
        sum    = add_cin(op_a, op_sub ? ~op_b : op_b, op_sub);
    end

    // State, pointer, owner and held result; reset clears everything at once.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            o_p0    <= '0;
            cout_p0 <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_vld) begin
                owner   <= grant_sel;
                o_p0    <= sum[WIDTH-1:0];
                cout_p0 <= sum[WIDTH];
            end
            if (state == RESP && state_nxt == IDLE)
                ptr <= ~owner;
        end
    end

    assign O    = o_p0;
    assign COUT = cout_p0;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenarios then random traffic
// against a transaction-level model of the arbiter.
module tb_addsub_arbiter;

    logic       CLK;
    logic       ASYNCRESETN;
    logic       VALID0, VALID1;
    logic       READY0, READY1;
    logic [7:0] A0, B0, A1, B1;
    logic       OP0, OP1;
    logic       OUT_VALID0, OUT_VALID1;
    logic       OUT_READY0, OUT_READY1;
    logic [7:0] O;
    logic       COUT;
    logic       BUSY;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit       m_held;
    bit       m_owner;
    bit       m_prio;
    bit [7:0] m_o;
    bit       m_cout;

    addsub_arbiter #(.WIDTH(8)) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .VALID0(VALID0), .VALID1(VALID1),
        .READY0(READY0), .READY1(READY1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .OP0(OP0), .OP1(OP1),
        .OUT_VALID0(OUT_VALID0), .OUT_VALID1(OUT_VALID1),
        .OUT_READY0(OUT_READY0), .OUT_READY1(OUT_READY1),
        .O(O), .COUT(COUT), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic m_reset();
        m_held  = 1'b0;
        m_owner = 1'b0;
        m_prio  = 1'b0;
        m_o     = 8'h00;
        m_cout  = 1'b0;
    endtask

    // Arithmetic result straight from the definition of add/subtract.
    task automatic m_compute(input bit [7:0] a, input bit [7:0] b, input bit sub);
        int t;
        if (sub) begin
            t      = int'(a) - int'(b);
            m_o    = t[7:0];
            m_cout = (a >= b);
        end else begin
            t      = int'(a) + int'(b);
            m_o    = t[7:0];
            m_cout = (t > 255);
        end
    endtask

    // One clock cycle: inputs already driven; check outputs, then advance.
    task automatic cycle();
        bit gv, gs, consume;
        #1;
        gv = 1'b0; gs = 1'b0;
        if (!m_held) begin
            if (VALID0 && VALID1) begin gv = 1'b1; gs = m_prio; end
            else if (VALID0)      begin gv = 1'b1; gs = 1'b0;   end
            else if (VALID1)      begin gv = 1'b1; gs = 1'b1;   end
        end
        consume = m_held && (m_owner ? OUT_READY1 : OUT_READY0);
        check("ready0",     {31'b0, READY0},     {31'b0, gv && !gs});
        check("ready1",     {31'b0, READY1},     {31'b0, gv && gs});
        check("out_valid0", {31'b0, OUT_VALID0}, {31'b0, m_held && !m_owner});
        check("out_valid1", {31'b0, OUT_VALID1}, {31'b0, m_held && m_owner});
        check("busy",       {31'b0, BUSY},       {31'b0, m_held});
        check("o",          {24'b0, O},          {24'b0, m_o});
        check("cout",       {31'b0, COUT},       {31'b0, m_cout});
        @(posedge CLK);
        if (gv) begin
            if (gs) m_compute(A1, B1, OP1);
            else    m_compute(A0, B0, OP0);
            m_owner = gs;
            m_held  = 1'b1;
        end else if (consume) begin
            m_held = 1'b0;
            m_prio = !m_owner;
        end
        #1;
    endtask

    task automatic idle_inputs();
        VALID0 = 0; VALID1 = 0; OP0 = 0; OP1 = 0;
        A0 = 0; B0 = 0; A1 = 0; B1 = 0;
        OUT_READY0 = 0; OUT_READY1 = 0;
    endtask

    initial begin
        idle_inputs();
        ASYNCRESETN = 1'b0;
        m_reset();
        #2;
        check("rst_ready0", {31'b0, READY0}, 0);
        check("rst_ready1", {31'b0, READY1}, 0);
        check("rst_ov0",    {31'b0, OUT_VALID0}, 0);
        check("rst_ov1",    {31'b0, OUT_VALID1}, 0);
        check("rst_busy",   {31'b0, BUSY}, 0);
        check("rst_o",      {24'b0, O}, 0);
        check("rst_cout",   {31'b0, COUT}, 0);
        @(posedge CLK); #1;
        ASYNCRESETN = 1'b1;

        // Add wrap on requester 0
        VALID0 = 1; OP0 = 0; A0 = 8'hFF; B0 = 8'h01; OUT_READY0 = 1;
        cycle();
        VALID0 = 0;
        #1;
        check("add_wrap_ov0", {31'b0, OUT_VALID0}, 1);
        check("add_wrap_o",   {24'b0, O}, 8'h00);
        check("add_wrap_c",   {31'b0, COUT}, 1);
        cycle();

        // Subtract with and without borrow on requester 1
        VALID1 = 1; OP1 = 1; A1 = 8'h05; B1 = 8'h07; OUT_READY1 = 1;
        cycle();
        VALID1 = 0;
        #1;
        check("sub_borrow_o", {24'b0, O}, 8'hFE);
        check("sub_borrow_c", {31'b0, COUT}, 0);
        cycle();
        VALID1 = 1; A1 = 8'h07; B1 = 8'h05;
        cycle();
        VALID1 = 0;
        #1;
        check("sub_nob_o", {24'b0, O}, 8'h02);
        check("sub_nob_c", {31'b0, COUT}, 1);
        cycle();
        check("idle_hold_o", {24'b0, O}, 8'h02);

        // Round-robin with both requesting and results always taken
        ASYNCRESETN = 0; #1; m_reset(); ASYNCRESETN = 1;
        VALID0 = 1; VALID1 = 1; OUT_READY0 = 1; OUT_READY1 = 1;
        A0 = 8'h10; B0 = 8'h20; OP0 = 0; A1 = 8'h30; B1 = 8'h01; OP1 = 1;
        #1;
        check("rr_first0", {31'b0, READY0}, 1);
        for (int i = 0; i < 8; i++) cycle();

        // Backpressure: requester 0 holds its result for three cycles
        idle_inputs();
        VALID0 = 1; A0 = 8'h81; B0 = 8'h90; OP0 = 0;
        cycle();
        VALID0 = 0; VALID1 = 1; A1 = 8'h11; B1 = 8'h22; OP1 = 0;
        for (int i = 0; i < 3; i++) cycle();
        check("bp_o", {24'b0, O}, 8'h11);
        check("bp_ready1", {31'b0, READY1}, 0);
        OUT_READY0 = 1;
        cycle();
        OUT_READY0 = 0;
        #1;
        check("bp_grant1", {31'b0, READY1}, 1);
        cycle();
        VALID1 = 0; OUT_READY1 = 1;
        cycle();
        cycle();

        // Reset between edges while requester 1 holds a result
        idle_inputs();
        VALID1 = 1; A1 = 8'hC3; B1 = 8'h3C; OP1 = 1;
        cycle();
        VALID1 = 0;
        check("pre_rst_ov1", {31'b0, OUT_VALID1}, 1);
        ASYNCRESETN = 0;
        #1;
        check("mid_rst_ov1",  {31'b0, OUT_VALID1}, 0);
        check("mid_rst_busy", {31'b0, BUSY}, 0);
        check("mid_rst_o",    {24'b0, O}, 0);
        m_reset();
        #1;
        ASYNCRESETN = 1;
        VALID0 = 1; VALID1 = 1; OUT_READY0 = 1; OUT_READY1 = 1;
        #1;
        check("post_rst_grant0", {31'b0, READY0}, 1);
        for (int i = 0; i < 4; i++) cycle();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            VALID0     = ($urandom_range(0, 3) != 0);
            VALID1     = ($urandom_range(0, 3) != 0);
            OP0        = $urandom_range(0, 1);
            OP1        = $urandom_range(0, 1);
            A0         = 8'($urandom);
            B0         = 8'($urandom);
            A1         = 8'($urandom);
            B1         = 8'($urandom);
            OUT_READY0 = ($urandom_range(0, 2) != 0);
            OUT_READY1 = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits.
REQ-002 The block SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port ASYNCRESETN, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have ports VALID0/VALID1, input, 1: requester n presents an operation.
REQ-005 The block SHALL have ports READY0/READY1, output, 1: operation from requester n accepted this cycle.
REQ-006 The block SHALL have ports A0/A1 and B0/B1, input, WIDTH: operands of requester n.
REQ-007 The block SHALL have ports OP0/OP1, input, 1: 0 = add (A+B), 1 = subtract (A-B).
REQ-008 The block SHALL have ports OUT_VALID0/OUT_VALID1, input-side OUT_READY0/OUT_READY1, 1: per-requester result handshake.
REQ-009 The block SHALL have port O, output, WIDTH: result, shared by both result channels.
REQ-010 The block SHALL have port COUT, output, 1: carry out of the adder (add: carry; subtract: 1 = no borrow).
REQ-011 The block SHALL have port BUSY, output, 1: high while a result is held.

Function
REQ-012 The block SHALL contain one shared WIDTH-bit adder with carry-in, used by at most one operation at a time.
REQ-013 The block SHALL implement states IDLE and RESP in a state machine.
REQ-014 In IDLE, the block SHALL grant exactly one requester with VALIDn=1, driving READYn=1 combinationally for that requester only, in the same cycle.
REQ-015 When both VALID0 and VALID1 are 1 in IDLE, the block SHALL grant the requester not served most recently (round-robin pointer).
REQ-016 When exactly one VALIDn is 1 in IDLE, the block SHALL grant it regardless of pointer.
REQ-017 On a handshake (VALIDn & READYn), the block SHALL register O and COUT, record owner n, and enter RESP next cycle.
REQ-018 For add, the block SHALL produce {COUT,O} = A + B + 0, computed at WIDTH+1 bits.
REQ-019 For subtract, the block SHALL produce {COUT,O} = A + ~B + 1, computed at WIDTH+1 bits; O wraps modulo 2^WIDTH.
REQ-020 In RESP, the block SHALL drive OUT_VALIDowner=1, OUT_VALIDother=0, READY0=READY1=0 and BUSY=1.
REQ-021 In RESP, O and COUT SHALL remain stable until OUT_READYowner=1.
REQ-022 On OUT_READYowner=1 in RESP, the block SHALL return to IDLE next cycle and set the pointer so the other requester has priority.
REQ-023 In RESP, OUT_READY of the non-owner SHALL be ignored.
REQ-024 No new grant SHALL occur in the cycle a result is consumed; peak throughput is one operation per 2 cycles.
REQ-025 Request-to-result latency SHALL be 1 cycle: OUT_VALID rises in the cycle after the accept.
REQ-026 In IDLE, OUT_VALID0/1 and BUSY SHALL be 0; O and COUT SHALL hold their last value.
REQ-027 A requester deasserting VALIDn without a handshake SHALL cause no state change.

Reset
REQ-028 ASYNCRESETN=0 SHALL immediately force state IDLE, pointer to requester 0 priority, O=0, COUT=0, and all READY/OUT_VALID/BUSY outputs to 0, independent of CLK.
REQ-029 Reset asserted in RESP SHALL discard the held result; no OUT_VALID pulse follows reset release.
REQ-030 After ASYNCRESETN rises, the block SHALL accept a request from the first rising CLK edge.

Verification
REQ-031 Add wrap: VALID0=1, OP0=0, A0=8'hFF, B0=8'h01 -> READY0=1 that cycle; next cycle OUT_VALID0=1, O=8'h00, COUT=1.
REQ-032 Subtract with borrow: OP1=1, A1=8'h05, B1=8'h07 -> O=8'hFE, COUT=0; A1=8'h07, B1=8'h05 -> O=8'h02, COUT=1.
REQ-033 Arbitration: after reset, VALID0=VALID1=1 held -> grants in order 0,1,0,1; each accept exactly 2 cycles after the previous one with OUT_READY tied 1.
REQ-034 Backpressure: OUT_READY0=0 for 3 cycles in RESP -> O, COUT, OUT_VALID0 stable; READY0=READY1=0; VALID1=1 is granted only after OUT_READY0=1.
REQ-035 Reset mid-operation: ASYNCRESETN=0 while OUT_VALID1=1, between clock edges -> OUT_VALID1, BUSY, O drop to 0 immediately; after release, VALID0=VALID1=1 -> requester 0 granted first.
